core_dmem_lsu: RTL and testbench

- Load/store unit in the MEM stage of the RV32I pipeline. Converts EX/MEM load/store requests into AXI4-Lite read/write transactions on the data memory bus.
- Drives HCU_DMEM_BUSY, the producer side of the hazard unit's dmem stall input. The hazard unit holds PC, IF/ID, ID/EX and EX/MEM while busy is high.
- Returns aligned, sign- or zero-extended load data to MEM/WB.

---
 rtl/core_dmem_lsu.sv | 277 +++++++++++++++++++++++++++
 tb/tb_core_dmem_lsu.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_lsu.sv
// core_dmem_lsu: MEM-stage load/store unit, EX/MEM requests to AXI4-Lite data bus.
// Optional bus-error reporting is enabled with `define LSU_BUS_ERR_EN.
//
// Ports:
//   CLK, RST           core clock, synchronous active-high reset
//   C_MEMREAD/WRITE    EX/MEM load / store request (read wins if both)
//   FUNCT3, ADDR       access size/sign and effective address
//   WDATA              store data (rs2)
//   RDATA              aligned, extended load data to MEM/WB (held)
//   DONE               one-cycle completion pulse
//   LSU_FAULT          misaligned/illegal access pulse (with DONE)
//   HCU_DMEM_BUSY      stall request to the hazard unit
//   M_AXI_*            AXI4-Lite master (AW, W, B, AR, R channels)
//   LSU_BUS_ERR        non-OKAY response pulse (0 unless LSU_BUS_ERR_EN)
module core_dmem_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter bit WORD_ALIGN_BUS = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  C_MEMREAD,
    input  logic                  C_MEMWRITE,
    input  logic [2:0]            FUNCT3,
    input  logic [31:0]           ADDR,
    input  logic [31:0]           WDATA,
    output logic [31:0]           RDATA,
    output logic                  DONE,
    output logic                  LSU_FAULT,
    output logic                  HCU_DMEM_BUSY,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic                  LSU_BUS_ERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WRESP,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        fault_q;
    logic [31:0] rdata_q;

    logic        req;
    logic        rd_req;
    logic        legal_ld;
    logic        legal_st;
    logic        misal;
    logic        bad_req;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_lane;
    logic [31:0] ld_ext;
    logic [ADDR_WIDTH-1:0] bus_addr;

    // ---------------- request decode ----------------
    assign req    = C_MEMREAD | C_MEMWRITE;
    assign rd_req = C_MEMREAD;

    always_comb begin
        legal_ld = 1'b0;
        legal_st = 1'b0;
        unique case (FUNCT3)
            3'b000, 3'b001, 3'b010: begin
                legal_ld = 1'b1;
                legal_st = 1'b1;
            end
            3'b100, 3'b101: legal_ld = 1'b1;
            default: ;
        endcase
    end

    assign misal = ((FUNCT3[1:0] == 2'b01) && ADDR[0]) ||
                   ((FUNCT3[1:0] == 2'b10) && (ADDR[1:0] != 2'b00));

    assign bad_req = rd_req ? (!legal_ld || misal) : (!legal_st || misal);

    // Store data is replicated so the slave can pick any lane via WSTRB.
    always_comb begin
        st_strb = 4'b1111;
        st_data = WDATA;
        unique case (FUNCT3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << ADDR[1:0];
                st_data = {4{WDATA[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << ADDR[1:0];
                st_data = {2{WDATA[15:0]}};
            end
            default: ;
        endcase
    end

    // ---------------- load extraction ----------------
    assign ld_lane = M_AXI_RDATA >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_ext = ld_lane;
        unique case (funct3_q)
            3'b000: ld_ext = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'b001: ld_ext = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'b100: ld_ext = {24'h0, ld_lane[7:0]};
            3'b101: ld_ext = {16'h0, ld_lane[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        bus_addr = addr_q[ADDR_WIDTH-1:0];
        if (WORD_ALIGN_BUS)
            bus_addr[1:0] = 2'b00;
    end

`ifdef LSU_BUS_ERR_EN
    logic bus_err_q;
    assign LSU_BUS_ERR = (state == ST_DONE) && bus_err_q;
`else
    assign LSU_BUS_ERR = 1'b0;
`endif

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            funct3_q  <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
`ifdef LSU_BUS_ERR_EN
            bus_err_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q    <= ADDR;
                        funct3_q  <= FUNCT3;
                        wstrb_q   <= st_strb;
                        wdata_q   <= st_data;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        fault_q   <= bad_req;
`ifdef LSU_BUS_ERR_EN
                        bus_err_q <= 1'b0;
`endif
                    end
                end
                ST_RDATA: begin
                    if (M_AXI_RVALID) begin
`ifdef LSU_BUS_ERR_EN
                        bus_err_q <= (M_AXI_RRESP != 2'b00);
                        rdata_q   <= (M_AXI_RRESP != 2'b00) ? 32'h0 : ld_ext;
`else
                        rdata_q   <= ld_ext;
`endif
                    end
                end
                ST_WADDR: begin
                    if (M_AXI_AWREADY)
                        aw_done_q <= 1'b1;
                    if (M_AXI_WREADY)
                        w_done_q <= 1'b1;
                end
                ST_WRESP: begin
`ifdef LSU_BUS_ERR_EN
                    if (M_AXI_BVALID)
                        bus_err_q <= (M_AXI_BRESP != 2'b00);
`endif
                end
                default: ;
            endcase
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_nx      = state;
        HCU_DMEM_BUSY = 1'b0;
        DONE          = 1'b0;
        LSU_FAULT     = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                HCU_DMEM_BUSY = req;
                if (req) begin
                    if (bad_req)
                        state_nx = ST_DONE;
                    else if (rd_req)
                        state_nx = ST_RADDR;
                    else
                        state_nx = ST_WADDR;
                end
            end
            ST_RADDR: begin
                HCU_DMEM_BUSY = 1'b1;
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY)
                    state_nx = ST_RDATA;
            end
            ST_RDATA: begin
                HCU_DMEM_BUSY = 1'b1;
                M_AXI_RREADY  = 1'b1;
                if (M_AXI_RVALID)
                    state_nx = ST_DONE;
            end
            ST_WADDR: begin
                HCU_DMEM_BUSY = 1'b1;
                M_AXI_AWVALID = !aw_done_q;
                M_AXI_WVALID  = !w_done_q;
                // Either channel may finish first; leave once both have.
                if ((aw_done_q || M_AXI_AWREADY) &&
                    (w_done_q || M_AXI_WREADY))
                    state_nx = ST_WRESP;
            end
            ST_WRESP: begin
                HCU_DMEM_BUSY = 1'b1;
                M_AXI_BREADY  = 1'b1;
                if (M_AXI_BVALID)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                DONE      = 1'b1;
                LSU_FAULT = fault_q;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign RDATA        = rdata_q;
    assign M_AXI_ARADDR = bus_addr;
    assign M_AXI_AWADDR = bus_addr;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    // Response codes are only consumed when bus-error reporting is built in.
    logic unused_bits;
    assign unused_bits = ^{M_AXI_RRESP, M_AXI_BRESP, addr_q};

endmodule

// File: tb/tb_core_dmem_lsu.sv
// tb_core_dmem_lsu: directed self-checking bench for core_dmem_lsu.
// Drives a simple AXI4-Lite slave by hand from the test tasks.
module tb_core_dmem_lsu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        C_MEMREAD, C_MEMWRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR, WDATA;
    logic [31:0] RDATA;
    logic        DONE, LSU_FAULT, HCU_DMEM_BUSY;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic        LSU_BUS_ERR;

    int checks = 0;
    int failures = 0;

    int          o_lat, o_busy, o_arv, o_awv;
    logic        o_flt, o_berr, o_done_busy;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_strb;

    always #5 CLK = ~CLK;

    core_dmem_lsu #(.ADDR_WIDTH(32), .WORD_ALIGN_BUS(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .C_MEMREAD(C_MEMREAD), .C_MEMWRITE(C_MEMWRITE),
        .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA),
        .RDATA(RDATA), .DONE(DONE), .LSU_FAULT(LSU_FAULT),
        .HCU_DMEM_BUSY(HCU_DMEM_BUSY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .LSU_BUS_ERR(LSU_BUS_ERR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic slave_zero_wait();
        M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1; M_AXI_RRESP = 2'b00;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        M_AXI_BVALID  = 1'b1; M_AXI_BRESP  = 2'b00;
    endtask

    // Issue one request and follow it to DONE, recording what was seen.
    // Cycle 1 is the request cycle; o_lat = -1 on timeout.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        o_lat = 1; o_busy = 0; o_arv = 0; o_awv = 0;
        o_addr = 32'hx; o_wdata = 32'hx; o_strb = 4'hx;
        C_MEMREAD = rd; C_MEMWRITE = wr; FUNCT3 = f3; ADDR = a; WDATA = wd;
        #1;
        while (DONE !== 1'b1 && o_lat < 20) begin
            if (HCU_DMEM_BUSY === 1'b1) o_busy++;
            if (M_AXI_ARVALID === 1'b1) begin
                o_arv++; o_addr = M_AXI_ARADDR;
            end
            if (M_AXI_AWVALID === 1'b1) begin
                o_awv++; o_addr = M_AXI_AWADDR;
                o_strb = M_AXI_WSTRB; o_wdata = M_AXI_WDATA;
            end
            tick();
            o_lat++;
        end
        if (DONE !== 1'b1) o_lat = -1;
        o_flt = LSU_FAULT; o_berr = LSU_BUS_ERR; o_done_busy = HCU_DMEM_BUSY;
        C_MEMREAD = 1'b0; C_MEMWRITE = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        C_MEMREAD = 1'b0; C_MEMWRITE = 1'b0; FUNCT3 = 3'b0;
        ADDR = 32'h0; WDATA = 32'h0; M_AXI_RDATA = 32'h0;
        slave_zero_wait();
        tick(); tick();
        checks++;
        if ({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID,
             M_AXI_BREADY} !== 5'b0) begin
            failures++;
            $display("FAIL reset_handshake got=%b exp=00000",
                     {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID,
                      M_AXI_WVALID, M_AXI_BREADY});
        end
        checks++;
        if ({DONE, LSU_FAULT, LSU_BUS_ERR, HCU_DMEM_BUSY} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {DONE, LSU_FAULT, LSU_BUS_ERR, HCU_DMEM_BUSY});
        end
        checks++;
        if (RDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=00000000", RDATA);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        M_AXI_RDATA = 32'hDEADBEEF;
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        checks++;
        if (o_lat !== 4) begin
            failures++; $display("FAIL lw_latency got=%0d exp=4", o_lat);
        end
        checks++;
        if (o_busy !== 3) begin
            failures++; $display("FAIL lw_busy_cycles got=%0d exp=3", o_busy);
        end
        checks++;
        if (o_arv !== 1 || o_addr !== 32'h100) begin
            failures++;
            $display("FAIL lw_araddr got=%h n=%0d exp=00000100 n=1", o_addr, o_arv);
        end
        checks++;
        if (o_done_busy !== 1'b0 || o_flt !== 1'b0) begin
            failures++;
            $display("FAIL lw_done_flags busy=%b fault=%b exp=0 0", o_done_busy, o_flt);
        end
        checks++;
        if (RDATA !== 32'hDEADBEEF) begin
            failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", RDATA);
        end
        checks++;
        if (DONE !== 1'b0) begin
            failures++; $display("FAIL lw_done_pulse got=%b exp=0", DONE);
        end
    endtask

    task automatic test_sub_word_loads();
        M_AXI_RDATA = 32'h80FF1234;
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        checks++;
        if (RDATA !== 32'hFFFFFF80 || o_addr !== 32'h100) begin
            failures++;
            $display("FAIL lb_103 got=%h addr=%h exp=ffffff80 addr=00000100",
                     RDATA, o_addr);
        end
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
        checks++;
        if (RDATA !== 32'h00000080) begin
            failures++; $display("FAIL lbu_103 got=%h exp=00000080", RDATA);
        end
        run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
        checks++;
        if (RDATA !== 32'h000080FF) begin
            failures++; $display("FAIL lhu_102 got=%h exp=000080ff", RDATA);
        end
        run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
        checks++;
        if (RDATA !== 32'hFFFF80FF) begin
            failures++; $display("FAIL lh_102 got=%h exp=ffff80ff", RDATA);
        end
        run_op(1'b1, 1'b0, 3'b100, 32'h101, 32'h0);
        checks++;
        if (RDATA !== 32'h00000012) begin
            failures++; $display("FAIL lbu_101 got=%h exp=00000012", RDATA);
        end
    endtask

    task automatic test_sh_slow_aw();
        int dn;
        int aw_again;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b1;
        C_MEMWRITE = 1'b1; C_MEMREAD = 1'b0;
        FUNCT3 = 3'b001; ADDR = 32'h206; WDATA = 32'h0000ABCD;
        tick();
        checks++;
        if (M_AXI_AWVALID !== 1'b1 || M_AXI_WVALID !== 1'b1 ||
            M_AXI_AWADDR !== 32'h204 || M_AXI_WSTRB !== 4'b1100 ||
            M_AXI_WDATA !== 32'hABCDABCD) begin
            failures++;
            $display("FAIL sh_issue v=%b%b addr=%h strb=%b data=%h exp=11 00000204 1100 abcdabcd",
                     M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WSTRB, M_AXI_WDATA);
        end
        tick();
        M_AXI_WREADY = 1'b0;
        checks++;
        if (M_AXI_WVALID !== 1'b0 || M_AXI_AWVALID !== 1'b1 ||
            HCU_DMEM_BUSY !== 1'b1) begin
            failures++;
            $display("FAIL sh_w_done wv=%b awv=%b busy=%b exp=0 1 1",
                     M_AXI_WVALID, M_AXI_AWVALID, HCU_DMEM_BUSY);
        end
        tick(); tick();
        M_AXI_AWREADY = 1'b1;
        tick();
        checks++;
        if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0 ||
            M_AXI_BREADY !== 1'b1) begin
            failures++;
            $display("FAIL sh_wresp awv=%b wv=%b bready=%b exp=0 0 1",
                     M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY);
        end
        dn = 0; aw_again = 0;
        for (int i = 0; i < 6; i++) begin
            if (DONE === 1'b1) begin
                dn++; C_MEMWRITE = 1'b0;
            end
            if (M_AXI_AWVALID === 1'b1 || M_AXI_WVALID === 1'b1) aw_again++;
            tick();
        end
        checks++;
        if (dn !== 1 || aw_again !== 0) begin
            failures++;
            $display("FAIL sh_single_done done=%0d reissue=%0d exp=1 0", dn, aw_again);
        end
        slave_zero_wait();
    endtask

    task automatic test_sw_and_hold();
        run_op(1'b0, 1'b1, 3'b010, 32'h300, 32'h12345678);
        checks++;
        if (o_lat !== 4 || o_strb !== 4'b1111 || o_wdata !== 32'h12345678 ||
            o_addr !== 32'h300) begin
            failures++;
            $display("FAIL sw_zero_wait lat=%0d strb=%b data=%h addr=%h exp=4 1111 12345678 00000300",
                     o_lat, o_strb, o_wdata, o_addr);
        end
        checks++;
        if (RDATA !== 32'h00000012) begin
            failures++; $display("FAIL rdata_hold got=%h exp=00000012", RDATA);
        end
        run_op(1'b0, 1'b1, 3'b000, 32'h302, 32'h000000A5);
        checks++;
        if (o_strb !== 4'b0100 || o_wdata !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL sb_302 strb=%b data=%h exp=0100 a5a5a5a5", o_strb, o_wdata);
        end
        M_AXI_RDATA = 32'hCAFEF00D;
        run_op(1'b1, 1'b1, 3'b010, 32'h400, 32'h0);
        checks++;
        if (o_arv !== 1 || o_awv !== 0 || RDATA !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rd_wins arv=%0d awv=%0d rdata=%h exp=1 0 cafef00d",
                     o_arv, o_awv, RDATA);
        end
    endtask

    task automatic test_faults();
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        checks++;
        if (o_lat !== 2 || o_flt !== 1'b1 || o_arv !== 0 || o_busy !== 1) begin
            failures++;
            $display("FAIL lw_misaligned lat=%0d fault=%b arv=%0d busy=%0d exp=2 1 0 1",
                     o_lat, o_flt, o_arv, o_busy);
        end
        run_op(1'b0, 1'b1, 3'b011, 32'h200, 32'h0);
        checks++;
        if (o_lat !== 2 || o_flt !== 1'b1 || o_awv !== 0) begin
            failures++;
            $display("FAIL st_illegal lat=%0d fault=%b awv=%0d exp=2 1 0",
                     o_lat, o_flt, o_awv);
        end
        run_op(1'b0, 1'b1, 3'b001, 32'h203, 32'h0);
        checks++;
        if (o_flt !== 1'b1 || o_awv !== 0) begin
            failures++;
            $display("FAIL sh_misaligned fault=%b awv=%0d exp=1 0", o_flt, o_awv);
        end
        checks++;
        if (LSU_FAULT !== 1'b0 || RDATA !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL fault_pulse fault=%b rdata=%h exp=0 cafef00d",
                     LSU_FAULT, RDATA);
        end
    endtask

    task automatic test_reset_mid_read();
        M_AXI_RVALID = 1'b0;
        C_MEMREAD = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h500;
        tick(); tick();
        checks++;
        if (M_AXI_RREADY !== 1'b1) begin
            failures++; $display("FAIL mid_read_rready got=%b exp=1", M_AXI_RREADY);
        end
        RST = 1'b1;
        tick();
        checks++;
        if ({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID,
             M_AXI_BREADY, DONE} !== 6'b0 || HCU_DMEM_BUSY !== 1'b1 ||
            RDATA !== 32'h0) begin
            failures++;
            $display("FAIL mid_read_reset hs=%b busy=%b rdata=%h exp=000000 1 00000000",
                     {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID,
                      M_AXI_BREADY, DONE}, HCU_DMEM_BUSY, RDATA);
        end
        C_MEMREAD = 1'b0;
        #1;
        checks++;
        if (HCU_DMEM_BUSY !== 1'b0) begin
            failures++; $display("FAIL mid_read_busy got=%b exp=0", HCU_DMEM_BUSY);
        end
        RST = 1'b0;
        slave_zero_wait();
        tick();
    endtask

    task automatic test_bus_err();
        logic exp_err;
`ifdef LSU_BUS_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        M_AXI_BRESP = 2'b10;
        run_op(1'b0, 1'b1, 3'b010, 32'h600, 32'h0);
        M_AXI_BRESP = 2'b00;
        checks++;
        if (o_lat !== 4 || o_berr !== exp_err) begin
            failures++;
            $display("FAIL sw_bresp_err lat=%0d err=%b exp=4 %b", o_lat, o_berr, exp_err);
        end
        checks++;
        if (LSU_BUS_ERR !== 1'b0) begin
            failures++; $display("FAIL bus_err_pulse got=%b exp=0", LSU_BUS_ERR);
        end
    endtask

    task automatic test_back_to_back();
        M_AXI_RDATA = 32'h11223344;
        run_op(1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
        M_AXI_RDATA = 32'h55667788;
        run_op(1'b1, 1'b0, 3'b000, 32'h701, 32'h0);
        checks++;
        if (o_lat !== 4 || RDATA !== 32'h00000077) begin
            failures++;
            $display("FAIL b2b_second lat=%0d rdata=%h exp=4 00000077", o_lat, RDATA);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_sh_slow_aw();
        test_sw_and_hold();
        test_faults();
        test_reset_mid_read();
        test_bus_err();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
